// File: rtl/clock_step_ctrl.sv
// Core clock-enable and reset sequencer with four modes: run, divide-by-2^N, debounced single-step and halt.
// All outputs are registered. A cpu_ce decision made in cycle n appears in cycle n+1; there is no backpressure.
module clock_step_ctrl #(
  parameter int RST_CYCLES = 16,
  parameter int DEB_CYCLES = 1000,
  parameter int MAX_DIV    = 24
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [1:0]  mode,
  input  logic [4:0]  div_sel,
  input  logic        step_btn,
  input  logic        soft_rst,
  output logic        cpu_ce,
  output logic        cpu_resetn,
  output logic [31:0] ce_count,
  output logic        hold
);

  localparam logic [0:0] RST_HOLD  = 1'b0;
  localparam logic [0:0] ACTIVE    = 1'b1;
  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_DIV  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;

  logic [0:0]         state;
  logic [15:0]        hold_cnt;
  logic [MAX_DIV-1:0] presc, presc_next, presc_reload;
  logic               in_div, in_div_next;
  logic [5:0]         div_exp;
  logic               ce_next;
  logic               btn_s1, btn_s2, deb_lvl, deb_prev;
  logic [19:0]        deb_cnt;
  logic               step_evt;

  assign step_evt = deb_lvl & ~deb_prev;

  always_comb begin
    div_exp      = ({1'b0, div_sel} > 6'(MAX_DIV)) ? 6'(MAX_DIV) : {1'b0, div_sel};
    presc_reload = {MAX_DIV{1'b1}} >> (6'(MAX_DIV) - div_exp);
  end

  // in_div is low on the first divided cycle, so entering the mode always reloads
  always_comb begin
    ce_next     = 1'b0;
    presc_next  = presc;
    in_div_next = 1'b0;
    if (state == ACTIVE) begin
      if (soft_rst) begin
        presc_next = '0;
      end else begin
        case (mode)
          MODE_RUN:  ce_next = 1'b1;
          MODE_DIV: begin
            in_div_next = 1'b1;
            if (!in_div) begin
              presc_next = presc_reload;
            end else if (presc == '0) begin
              ce_next    = 1'b1;
              presc_next = presc_reload;
            end else begin
              presc_next = presc - {{(MAX_DIV-1){1'b0}}, 1'b1};
            end
          end
          MODE_STEP: ce_next = step_evt;
          default:   ce_next = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b0;
      deb_lvl  <= 1'b0;
      deb_prev <= 1'b0;
      deb_cnt  <= '0;
    end else begin
      btn_s1   <= step_btn;
      btn_s2   <= btn_s1;
      deb_prev <= deb_lvl;
      if (btn_s2 == deb_lvl) begin
        deb_cnt <= '0;
      end else if (deb_cnt == 20'(DEB_CYCLES - 1)) begin
        deb_lvl <= ~deb_lvl;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 20'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= RST_HOLD;
      hold_cnt   <= 16'(RST_CYCLES);
      cpu_ce     <= 1'b0;
      cpu_resetn <= 1'b0;
      hold       <= 1'b1;
      ce_count   <= '0;
      presc      <= '0;
      in_div     <= 1'b0;
    end else begin
      cpu_ce   <= ce_next;
      presc    <= presc_next;
      in_div   <= in_div_next;
      ce_count <= ce_count + {31'd0, cpu_ce};
      case (state)
        RST_HOLD: begin
          hold_cnt <= hold_cnt - 16'd1;
          if (hold_cnt == 16'd1) begin
            state      <= ACTIVE;
            cpu_resetn <= 1'b1;
            hold       <= 1'b0;
          end
        end
        default: begin
          if (soft_rst) begin
            state      <= RST_HOLD;
            hold_cnt   <= 16'(RST_CYCLES);
            cpu_resetn <= 1'b0;
            hold       <= 1'b1;
            ce_count   <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_step_ctrl.sv
// Bench for clock_step_ctrl: directed scenarios plus random mode/button/soft-reset traffic,
// checked every cycle against a behavioural model and pinned with hand-computed literals.
module tb_clock_step_ctrl;

  localparam int RST  = 16;
  localparam int DEB  = 4;
  localparam int MAXD = 6;

  logic        clk;
  logic        resetn;
  logic [1:0]  mode;
  logic [4:0]  div_sel;
  logic        step_btn;
  logic        soft_rst;
  logic        cpu_ce;
  logic        cpu_resetn;
  logic [31:0] ce_count;
  logic        hold;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  bit          m_active;
  int          m_left;
  bit          m_ce;
  logic [31:0] m_cnt;
  bit          m_div_on;
  int          m_wait;
  bit          m_s1, m_s2, m_deb, m_evt;
  int          m_run;

  clock_step_ctrl #(.RST_CYCLES(RST), .DEB_CYCLES(DEB), .MAX_DIV(MAXD)) dut (
    .clk(clk), .resetn(resetn), .mode(mode), .div_sel(div_sel), .step_btn(step_btn),
    .soft_rst(soft_rst), .cpu_ce(cpu_ce), .cpu_resetn(cpu_resetn), .ce_count(ce_count), .hold(hold)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_left = RST; m_ce = 0; m_cnt = '0; m_div_on = 0; m_wait = 0;
    m_s1 = 0; m_s2 = 0; m_deb = 0; m_evt = 0; m_run = 0;
  endtask

  // One clock edge worth of the rules: hold countdown, mode decisions, step debounce.
  task automatic model_update();
    int d;
    bit nce;
    if (!resetn) begin
      model_reset();
      return;
    end
    d   = (int'(div_sel) > MAXD) ? MAXD : int'(div_sel);
    nce = 0;
    m_cnt = m_cnt + 32'(m_ce);
    if (!m_active) begin
      m_left--;
      if (m_left == 0) m_active = 1;
      m_div_on = 0;
    end else if (soft_rst) begin
      m_active = 0; m_left = RST; m_cnt = '0; m_div_on = 0;
    end else begin
      case (mode)
        2'b00: nce = 1;
        2'b01: begin
          if (!m_div_on) begin
            m_div_on = 1;
            m_wait   = 1 << d;
          end else begin
            m_wait--;
            if (m_wait == 0) begin
              nce    = 1;
              m_wait = 1 << d;
            end
          end
        end
        2'b10: nce = m_evt;
        default: nce = 0;
      endcase
      if (mode != 2'b01) m_div_on = 0;
    end
    m_ce  = nce;
    m_evt = 0;
    if (m_s2 == m_deb) begin
      m_run = 0;
    end else begin
      m_run++;
      if (m_run == DEB) begin
        m_deb = !m_deb;
        m_run = 0;
        m_evt = m_deb;
      end
    end
    m_s2 = m_s1;
    m_s1 = step_btn;
  endtask

  task automatic compare_all();
    chk("cpu_ce",     32'(cpu_ce),     32'(m_ce));
    chk("cpu_resetn", 32'(cpu_resetn), 32'(m_active));
    chk("hold",       32'(hold),       32'(!m_active));
    chk("ce_count",   ce_count,        m_cnt);
  endtask

  task automatic step1();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int pulses, first, last, badgap, rise, mode_left, btn_left;
    resetn = 1'b0; mode = 2'b11; div_sel = 5'd0; step_btn = 1'b0; soft_rst = 1'b0;
    model_reset();
    repeat (3) step1();
    chk("rst_cpu_ce", 32'(cpu_ce), 32'd0);
    chk("rst_cpu_resetn", 32'(cpu_resetn), 32'd0);
    chk("rst_hold", 32'(hold), 32'd1);
    chk("rst_ce_count", ce_count, 32'd0);

    // release between edges: the following posedges are edges 1..16
    resetn = 1'b1;
    repeat (RST - 1) step1();
    chk("hold_edge15_resetn", 32'(cpu_resetn), 32'd0);
    chk("hold_edge15_hold", 32'(hold), 32'd1);
    step1();
    chk("hold_edge16_resetn", 32'(cpu_resetn), 32'd1);
    chk("hold_edge16_hold", 32'(hold), 32'd0);
    chk("hold_edge16_ce", 32'(cpu_ce), 32'd0);

    // run 10 cycles, then halt
    mode = 2'b00; pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step1();
      if (cpu_ce) pulses++;
    end
    mode = 2'b11;
    step1();
    chk("run_pulses", 32'(pulses), 32'd10);
    chk("halt_ce", 32'(cpu_ce), 32'd0);
    chk("halt_count", ce_count, 32'd10);
    chk("model_count", m_cnt, 32'd10);
    step1();
    chk("halt_count_stays", ce_count, 32'd10);

    // divided, div_sel=3: pulses 8 cycles apart, first 8 after entry
    mode = 2'b01; div_sel = 5'd3; pulses = 0; first = -1; last = 0; badgap = 0;
    for (int i = 1; i <= 65; i++) begin
      step1();
      if (cpu_ce) begin
        if (first < 0) first = i;
        else if (i - last != 8) badgap++;
        last = i;
        pulses++;
      end
    end
    chk("div3_pulses", 32'(pulses), 32'd8);
    chk("div3_first_offset", 32'(first - 1), 32'd8);
    chk("div3_bad_gaps", 32'(badgap), 32'd0);

    // div_sel=31 clamps to MAX_DIV
    mode = 2'b11; step1();
    mode = 2'b01; div_sel = 5'd31; pulses = 0; first = -1;
    for (int i = 1; i <= 129; i++) begin
      step1();
      if (cpu_ce) begin
        if (first < 0) first = i;
        pulses++;
      end
    end
    chk("clamp_first_offset", 32'(first - 1), 32'd64);
    chk("clamp_pulses", 32'(pulses), 32'd2);

    // step mode: bounce, then a stable press and release
    mode = 2'b10; pulses = 0; first = -1;
    for (int i = 0; i < 4; i++) begin
      step_btn = (i % 2 == 0);
      step1();
      if (cpu_ce) pulses++;
    end
    for (int i = 1; i <= 20; i++) begin
      step_btn = (i <= 10);
      step1();
      if (cpu_ce) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    chk("step_pulses", 32'(pulses), 32'd1);
    chk("step_latency", 32'(first), 32'd7);
    pulses = 0;
    for (int i = 1; i <= 13; i++) begin
      step_btn = (i <= 3);
      step1();
      if (cpu_ce) pulses++;
    end
    chk("short_press_pulses", 32'(pulses), 32'd0);

    // soft reset in run mode; a second request during hold is ignored
    mode = 2'b00;
    repeat (20) step1();
    soft_rst = 1'b1;
    step1();
    soft_rst = 1'b0;
    chk("soft_resetn", 32'(cpu_resetn), 32'd0);
    chk("soft_ce", 32'(cpu_ce), 32'd0);
    chk("soft_count", ce_count, 32'd0);
    chk("soft_hold", 32'(hold), 32'd1);
    rise = -1;
    for (int k = 1; k <= 40 && rise < 0; k++) begin
      soft_rst = (k == 4);
      step1();
      soft_rst = 1'b0;
      if (cpu_resetn) rise = k;
    end
    chk("soft_hold_len", 32'(rise), 32'd16);

    // random traffic
    mode_left = 0; btn_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (mode_left == 0) begin
        mode      = 2'($urandom_range(0, 3));
        mode_left = $urandom_range(1, 40);
        div_sel   = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(7, 31)) : 5'($urandom_range(0, 3));
      end
      mode_left--;
      if (btn_left == 0) begin
        step_btn = !step_btn;
        btn_left = $urandom_range(1, 12);
      end
      btn_left--;
      soft_rst = ($urandom_range(0, 199) == 0);
      step1();
      soft_rst = 1'b0;
    end

    // ce_count wrap: preload near the top while halted, then two run pulses
    mode = 2'b11; step_btn = 1'b0;
    repeat (20) step1();
    force dut.ce_count = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    step1();
    release dut.ce_count;
    mode = 2'b00;
    step1();
    step1();
    mode = 2'b11;
    chk("wrap_top", ce_count, 32'hFFFF_FFFF);
    step1();
    chk("wrap_zero", ce_count, 32'd0);
    chk("wrap_ce_off", 32'(cpu_ce), 32'd0);

    // asynchronous reset in divided mode with a pulse in flight
    mode = 2'b01; div_sel = 5'd0;
    repeat (4) step1();
    chk("pre_arst_ce", 32'(cpu_ce), 32'd1);
    #1 resetn = 1'b0;
    #1;
    chk("arst_ce", 32'(cpu_ce), 32'd0);
    chk("arst_resetn", 32'(cpu_resetn), 32'd0);
    chk("arst_hold", 32'(hold), 32'd1);
    chk("arst_count", ce_count, 32'd0);
    model_reset();
    repeat (2) step1();
    resetn = 1'b1;
    repeat (RST + 5) step1();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_step_ctrl.md
Name: clock_step_ctrl

Overview:
- Sequences the core's clock-enable and reset from a single board clock. Replaces clock division with a clock-enable scheme.
- Provides four modes: full speed, divide-by-2^N, debounced single-step from a push button, and halt.
- Generates a stretched, synchronously released core reset that can also be requested by software.
- Sits between the board clock/reset generation and the CPU core; the core gates every state update with cpu_ce.

Parameters:
RST_CYCLES, 16, clk cycles cpu_resetn is held low after resetn release or soft_rst (1..65535)
DEB_CYCLES, 1000, consecutive stable cycles required to accept a new step_btn level (1..2^20-1)
MAX_DIV, 24, largest accepted div_sel; larger values clamp to MAX_DIV

Ports:
clk  in  1  design clock
resetn  in  1  asynchronous active-low reset
mode  in  2  00 run, 01 divided, 10 step, 11 halt
div_sel  in  5  divide exponent; divided mode pulses cpu_ce once per 2^div_sel cycles
step_btn  in  1  raw asynchronous push button, active high, bouncy
soft_rst  in  1  synchronous one-cycle core reset request
cpu_ce  out  1  registered clock enable for the core
cpu_resetn  out  1  registered active-low core reset
ce_count  out  32  number of cpu_ce pulses since last core reset; wraps
hold  out  1  high while in reset-hold state

Behaviour:
- Reset values (resetn low): cpu_ce=0, cpu_resetn=0, hold=1, ce_count=0, hold counter=RST_CYCLES, prescaler=0, synchronizer and debounced level=0, FSM=RST_HOLD.
- FSM RST_HOLD:
  - Hold counter decrements once per clk.
  - When it reaches 0: move to ACTIVE, cpu_resetn=1, hold=0.
  - cpu_resetn rises on exactly the RST_CYCLES-th rising clk edge after resetn deasserts.
  - cpu_ce=0 throughout.
- FSM ACTIVE:
  - soft_rst=1 returns to RST_HOLD on the next edge: hold counter reloads RST_CYCLES, cpu_resetn=0, cpu_ce=0, ce_count=0, prescaler=0.
  - soft_rst takes priority over any cpu_ce pulse in the same cycle.
  - soft_rst is ignored in RST_HOLD; it does not restart the count.
- step_btn path:
  - 2-flop synchronizer, then debouncer.
  - Debouncer counter resets whenever the synchronized level equals the debounced level. Otherwise it increments; on reaching DEB_CYCLES the debounced level toggles and the counter clears.
  - Step event = 0->1 transition of the debounced level. Events occurring outside ACTIVE+step mode are discarded, not queued.
- cpu_ce in ACTIVE, registered; a decision made in cycle n appears in cycle n+1:
  - run (00): cpu_ce=1 every cycle.
  - divided (01):
    - Down-counting prescaler. When the prescaler is 0, pulse cpu_ce and reload (2^d)-1, with d=min(div_sel, MAX_DIV).
    - Entering divided mode from any other mode loads (2^d)-1, so the first pulse comes 2^d cycles later.
    - d=0 gives a pulse every cycle.
    - A div_sel change takes effect at the next reload.
  - step (10): cpu_ce=1 for exactly one cycle per step event, in the cycle after the event is detected.
  - halt (11): cpu_ce=0.
- A mode change takes effect on the next edge. A pulse already registered completes; it is never truncated.
- ce_count increments on each cycle cpu_ce=1. It wraps 0xFFFFFFFF->0 and clears on resetn or soft_rst.
- resetn assertion mid-operation immediately forces all reset values, including cpu_ce=0, asynchronously.
- Prescaler width is MAX_DIV bits; no overflow at d=MAX_DIV.

Test Plan:
- RST_CYCLES=16: release resetn at edge 0 -> cpu_resetn=0, hold=1 through edge 15; cpu_resetn=1, hold=0 from edge 16; cpu_ce=0 until then.
- After reset, mode=00 for 10 cycles then mode=11 -> 10 consecutive cpu_ce pulses, ce_count=10, then cpu_ce=0 one cycle after the switch, ce_count stays 10.
- mode=01, div_sel=3 for 64 cycles -> exactly 8 pulses spaced 8 cycles apart, first at 8 cycles after entry. div_sel=31 -> clamped to 24 with no pulse within 2^24-1 cycles.
- DEB_CYCLES=4, mode=10: step_btn bounces 1,0,1,0 then held high 10 cycles then low 10 cycles -> exactly one cpu_ce pulse, at cycle 2 (sync) + 4 (debounce) + 1 after the stable rise. A stable press of only 3 cycles -> no pulse.
- soft_rst at cycle 20 in run mode -> cpu_resetn=0 and cpu_ce=0 from cycle 21, ce_count=0, cpu_resetn=1 again 16 cycles later. A second soft_rst during hold does not extend the hold.
- Force ce_count=0xFFFFFFFE via run mode in a shortened bench build -> wraps to 0 after 2 more pulses. resetn asserted mid-divided-mode -> all outputs at reset values without waiting for a clk edge.
